uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver with a first-word-fall-through (FWFT) receive FIFO.

---
 rtl/uart_rx_fifo.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable baud, data bits, parity, stop bits) feeding an FWFT receive FIFO.
// Push lands 1 cycle after the last stop-bit sample; rx_valid follows 1 cycle later; full FIFO drops and pulses overrun.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 125_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int BIT_TICKS = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int MID       = BIT_TICKS / 2;
    localparam int CW        = $clog2(BIT_TICKS);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] C_LAST = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] C_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] C_S1   = CW'(MID);
    localparam logic [CW-1:0] C_S2   = CW'(MID + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HI} state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rxs, rxs_d;
    logic [CW-1:0]        cnt;
    logic                 s0, s1, maj, at_smp, at_end;
    logic [2:0]           bit_idx;
    logic                 stop_idx, stop_ok, par_bit, par_x, par_bad;
    logic [DATA_BITS-1:0] shreg;
    logic                 push_nxt, fe_nxt, pe_nxt, push_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    // third sample is the live rxs at MID+1, so the vote resolves in that cycle
    assign maj    = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    assign at_smp = (cnt == C_S2);
    assign at_end = (cnt == C_LAST);
    assign par_x  = ^{shreg, par_bit};
    assign par_bad = (PARITY == 1) ? ~par_x : (PARITY == 2) ? par_x : 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push_nxt  = 1'b0;
        fe_nxt    = 1'b0;
        pe_nxt    = 1'b0;
        case (state)
            IDLE:    if (rxs_d && !rxs) state_nxt = START;
            START: begin
                if (at_smp && maj) state_nxt = IDLE;
                else if (at_end)   state_nxt = DATA;
            end
            DATA:    if (at_end && bit_idx == 3'(DATA_BITS - 1))
                         state_nxt = (PARITY != 0) ? PAR : STOP;
            PAR:     if (at_end) state_nxt = STOP;
            STOP: begin
                if (at_smp && stop_idx == 1'(STOP_BITS - 1)) begin
                    if (!(stop_ok && maj)) begin
                        fe_nxt    = 1'b1;
                        state_nxt = WAIT_HI;
                    end else if (par_bad) begin
                        pe_nxt    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        push_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_HI: if (rxs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            s0         <= 1'b1;
            s1         <= 1'b1;
            shreg      <= '0;
            bit_idx    <= '0;
            par_bit    <= 1'b0;
            stop_idx   <= 1'b0;
            stop_ok    <= 1'b1;
            push_q     <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == IDLE || state == WAIT_HI || at_end) cnt <= '0;
            else                                              cnt <= cnt + CW'(1);
            if (cnt == C_S0) s0 <= rxs;
            if (cnt == C_S1) s1 <= rxs;
            if (state == DATA && at_smp) shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (state != DATA)   bit_idx <= '0;
            else if (at_end)     bit_idx <= bit_idx + 3'd1;
            if (state == PAR && at_smp) par_bit <= maj;
            if (state != STOP) begin
                stop_idx <= 1'b0;
                stop_ok  <= 1'b1;
            end else begin
                if (at_smp) stop_ok  <= stop_ok & maj;
                if (at_end) stop_idx <= ~stop_idx;
            end
            push_q     <= push_nxt;
            frame_err  <= fe_nxt;
            parity_err <= pe_nxt;
        end
    end

    assign busy = (state != IDLE);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 full, pop, wr_en;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rx_valid = (wr_ptr != rd_ptr);
    assign pop      = rx_valid && rx_ready;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign wr_en    = push_q && (!full || pop);
    assign rx_data  = rx_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            overrun <= push_q && full && !pop;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: dut0 is 8N1, dut1 is 8E2; both run at 17 clocks per bit.
module tb_uart_rx_fifo;
    localparam int T     = 17;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx0, rx1, ready0, ready1;
    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1, frame_err0, frame_err1;
    logic       parity_err0, parity_err1, overrun0, overrun1, busy0, busy1;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_HZ(1_000_000), .BAUD(60_000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset_n(reset_n), .rx(rx0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .rx_ready(ready0), .frame_err(frame_err0), .parity_err(parity_err0),
        .overrun(overrun0), .busy(busy0));

    uart_rx_fifo #(.CLK_HZ(1_000_000), .BAUD(60_000), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset_n(reset_n), .rx(rx1), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .rx_ready(ready1), .frame_err(frame_err1), .parity_err(parity_err1),
        .overrun(overrun1), .busy(busy1));

    int n_cmp = 0;
    int n_bad = 0;
    int fe_c[2], pe_c[2], ov_c[2];
    int fe_exp[2], pe_exp[2], ov_exp[2];
    int bcyc0 = 0;
    logic [7:0] pop0[$], pop1[$], mq0[$], mq1[$], exp0[$], exp1[$];

    initial begin
        for (int i = 0; i < 2; i++) begin
            fe_c[i] = 0; pe_c[i] = 0; ov_c[i] = 0;
            fe_exp[i] = 0; pe_exp[i] = 0; ov_exp[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (frame_err0)  fe_c[0]++;
        if (parity_err0) pe_c[0]++;
        if (overrun0)    ov_c[0]++;
        if (frame_err1)  fe_c[1]++;
        if (parity_err1) pe_c[1]++;
        if (overrun1)    ov_c[1]++;
        if (busy0)       bcyc0++;
        if (rx_valid0 && ready0) pop0.push_back(rx_data0);
        if (rx_valid1 && ready1) pop1.push_back(rx_data1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx1 = v;
        else     rx0 = v;
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit has_par, input bit pbit,
                        input int nstop, input logic [1:0] stopv);
        drive(sel, 1'b0);
        wait_clk(T);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            wait_clk(T);
        end
        if (has_par) begin
            drive(sel, pbit);
            wait_clk(T);
        end
        for (int i = 0; i < nstop; i++) begin
            drive(sel, stopv[i]);
            wait_clk(T);
        end
    endtask

    // reference: good frames enter a DEPTH-entry queue, errors only bump counters
    task automatic model_frame(input bit sel, input logic [7:0] d, input bit stop_ok, input bit par_ok);
        if (!stop_ok)     fe_exp[sel]++;
        else if (!par_ok) pe_exp[sel]++;
        else if (sel) begin
            if (mq1.size() == DEPTH) ov_exp[1]++;
            else                     mq1.push_back(d);
        end else begin
            if (mq0.size() == DEPTH) ov_exp[0]++;
            else                     mq0.push_back(d);
        end
    endtask

    task automatic model_drain(input bit sel);
        if (sel) while (mq1.size() > 0) exp1.push_back(mq1.pop_front());
        else     while (mq0.size() > 0) exp0.push_back(mq0.pop_front());
    endtask

    task automatic pop_all(input bit sel, input string tag);
        if (sel) ready1 = 1'b1; else ready0 = 1'b1;
        wait_clk(DEPTH + 2);
        if (sel) ready1 = 1'b0; else ready0 = 1'b0;
        model_drain(sel);
        if (sel) chk({tag, "_popcnt"}, 32'(pop1.size()), 32'(exp1.size()));
        else     chk({tag, "_popcnt"}, 32'(pop0.size()), 32'(exp0.size()));
    endtask

    task automatic check_state(input bit sel, input string tag, input bit busy_e);
        logic       v, b;
        logic [7:0] d, h;
        int         n;
        v = sel ? rx_valid1 : rx_valid0;
        d = sel ? rx_data1  : rx_data0;
        b = sel ? busy1     : busy0;
        n = sel ? mq1.size() : mq0.size();
        h = 8'h00;
        if (n != 0) h = sel ? mq1[0] : mq0[0];
        chk({tag, "_valid"}, 32'(v), 32'(n != 0));
        if (n != 0) chk({tag, "_data"}, 32'(d), 32'(h));
        chk({tag, "_busy"}, 32'(b), 32'(busy_e));
        chk({tag, "_ferr"}, fe_c[sel], fe_exp[sel]);
        chk({tag, "_perr"}, pe_c[sel], pe_exp[sel]);
        chk({tag, "_ovr"},  ov_c[sel], ov_exp[sel]);
    endtask

    initial begin
        int         b0;
        logic [7:0] d;
        logic [7:0] a5;
        logic [1:0] sv;
        bit         sel, bad_par;

        reset_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b0; ready1 = 1'b0;
        wait_clk(5);
        chk("rst_valid0", 32'(rx_valid0), 0);
        chk("rst_data0",  32'(rx_data0), 0);
        chk("rst_busy0",  32'(busy0), 0);
        chk("rst_pulses0", 32'({frame_err0, parity_err0, overrun0}), 0);
        chk("rst_valid1", 32'(rx_valid1), 0);
        chk("rst_busy1",  32'(busy1), 0);
        reset_n = 1'b1;
        wait_clk(2 * T);

        send(0, 8'h33, 0, 0, 1, 2'b11);
        model_frame(0, 8'h33, 1, 1);
        check_state(0, "f33", 0);
        pop_all(0, "f33");

        b0 = bcyc0;
        rx0 = 1'b0;
        wait_clk(6);
        rx0 = 1'b1;
        wait_clk(2 * T);
        chk("glitch_busy_seen", 32'((bcyc0 - b0) > 0 && (bcyc0 - b0) < T), 1);
        check_state(0, "glitch", 0);

        send(1, 8'h07, 1, 1, 2, 2'b11);
        model_frame(1, 8'h07, 1, 1);
        check_state(1, "even_ok", 0);
        pop_all(1, "even_ok");
        send(1, 8'h07, 1, 0, 2, 2'b11);
        model_frame(1, 8'h07, 1, 0);
        wait_clk(T);
        check_state(1, "even_bad", 0);

        send(0, 8'h5A, 0, 0, 1, 2'b00);
        wait_clk(3 * T);
        model_frame(0, 8'h5A, 0, 1);
        check_state(0, "ferr_low", 1);
        rx0 = 1'b1;
        wait_clk(T);
        check_state(0, "ferr_rel", 0);
        send(0, 8'h55, 0, 0, 1, 2'b11);
        model_frame(0, 8'h55, 1, 1);
        check_state(0, "f55", 0);
        pop_all(0, "f55");

        for (int i = 1; i <= 5; i++) begin
            send(0, 8'(i), 0, 0, 1, 2'b11);
            model_frame(0, 8'(i), 1, 1);
        end
        wait_clk(T);
        check_state(0, "ovr", 0);
        pop_all(0, "ovr");

        send(0, 8'h3C, 0, 0, 1, 2'b11);
        model_frame(0, 8'h3C, 1, 1);
        check_state(0, "pre_rst", 0);
        a5 = 8'hA5;
        rx0 = 1'b0;
        wait_clk(T);
        for (int i = 0; i < 3; i++) begin
            rx0 = a5[i];
            wait_clk(T);
        end
        rx0 = a5[3];
        wait_clk(T / 2);
        reset_n = 1'b0;
        rx0 = 1'b1;
        mq0.delete();
        wait_clk(2);
        chk("mid_rst_valid", 32'(rx_valid0), 0);
        chk("mid_rst_data",  32'(rx_data0), 0);
        chk("mid_rst_busy",  32'(busy0), 0);
        reset_n = 1'b1;
        wait_clk(2 * T);
        check_state(0, "post_rst", 0);
        send(0, 8'hA5, 0, 0, 1, 2'b11);
        model_frame(0, 8'hA5, 1, 1);
        check_state(0, "fA5", 0);
        pop_all(0, "fA5");

        ready0 = 1'b1;
        ready1 = 1'b1;
        for (int it = 0; it < 24; it++) begin
            sel = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            sv  = 2'b11;
            bad_par = 1'b0;
            if (sel) begin
                bad_par = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 4) == 0) sv = 2'($urandom_range(0, 2));
                send(1, d, 1, (^d) ^ bad_par, 2, sv);
            end else begin
                if ($urandom_range(0, 4) == 0) sv = 2'b10;
                send(0, d, 0, 0, 1, sv);
            end
            drive(sel, 1'b1);
            wait_clk(2 * T);
            model_frame(sel, d, sv == 2'b11, !bad_par);
            model_drain(sel);
            check_state(sel, "rnd", 0);
            if (sel) chk("rnd_popcnt1", 32'(pop1.size()), 32'(exp1.size()));
            else     chk("rnd_popcnt0", 32'(pop0.size()), 32'(exp0.size()));
        end
        ready0 = 1'b0;
        ready1 = 1'b0;

        chk("final_popcnt0", 32'(pop0.size()), 32'(exp0.size()));
        chk("final_popcnt1", 32'(pop1.size()), 32'(exp1.size()));
        for (int i = 0; i < exp0.size() && i < pop0.size(); i++)
            chk($sformatf("order0_%0d", i), 32'(pop0[i]), 32'(exp0[i]));
        for (int i = 0; i < exp1.size() && i < pop1.size(); i++)
            chk($sformatf("order1_%0d", i), 32'(pop1[i]), 32'(exp1[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
